// File: rtl/reciprocal_seq.sv
// Sequential signed Q12.12 reciprocal: normalise with a leading-zero count, refine 1/d by
// Newton-Raphson on one shared 24x24 multiplier, then denormalise, saturate and re-sign.
module reciprocal_seq #(
  parameter int ITERS = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [23:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [23:0] o_data,
  output logic        o_sat
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_SEED  = 3'd2,
    S_MUL_A = 3'd3,
    S_MUL_B = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam int          LZC_WIDTH    = 24;
  localparam logic [23:0] C_SEED_OFS   = 24'hB4B4B4;  // 48/17 in Q2.22, truncated
  localparam logic [23:0] C_SEED_SLOPE = 24'h787878;  // 32/17 in Q2.22, truncated
  localparam logic [23:0] C_TWO        = 24'h800000;  // 2.0 in Q2.22
  localparam logic [23:0] C_SAT_POS    = 24'h7FFFFF;
  localparam logic [1:0]  IT_LAST      = 2'(ITERS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sgn;
  logic [23:0] r_mag;
  logic [4:0]  r_lz;
  logic [23:0] r_d;
  logic [23:0] r_x;
  logic [23:0] r_t;
  logic [1:0]  r_it;
  logic        r_busy;
  logic        r_done;
  logic [23:0] r_data;
  logic        r_sat;

  logic [23:0] w_mag_in;
  logic [4:0]  w_lz;
  logic [23:0] w_mul_a;
  logic [23:0] w_mul_b;
  logic [47:0] w_prod;
  logic [47:0] w_x_ext;
  logic [47:0] w_scaled;
  logic        w_res_sat;
  logic [23:0] w_res_mag;
  logic [23:0] w_res;
  logic        w_unused_prod_lo;

  assign w_mag_in = i_data[23] ? (24'd0 - i_data) : i_data;

  // Leading-zero count of the captured magnitude; an all-zero input yields LZC_WIDTH.
  always_comb begin : lzc_24
    w_lz = 5'(LZC_WIDTH);
    for (int i = 0; i < LZC_WIDTH; i++) begin
      if (r_mag[i]) w_lz = 5'(LZC_WIDTH - 1 - i);
    end
  end

  // One multiplier shared by the seed, d*x and x*(2-t) steps.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_SEED: begin
        w_mul_a = C_SEED_SLOPE;
        w_mul_b = r_d;
      end
      S_MUL_A: begin
        w_mul_a = r_d;
        w_mul_b = r_x;
      end
      S_MUL_B: begin
        w_mul_a = r_x;
        w_mul_b = C_TWO - r_t;
      end
      default: ;
    endcase
  end

  assign w_prod           = {24'd0, w_mul_a} * {24'd0, w_mul_b};
  assign w_unused_prod_lo = ^w_prod[21:0];

  // x holds 2^22/d; the Q12.12 result is x * 2^(lz-22).
  assign w_x_ext = {24'd0, r_x};
  always_comb begin
    if (r_lz < 5'd22) w_scaled = w_x_ext >> (5'd22 - r_lz);
    else              w_scaled = w_x_ext << (r_lz - 5'd22);
  end

  assign w_res_sat = (r_mag == 24'd0) || (w_scaled > 48'h7FFFFF);
  assign w_res_mag = w_res_sat ? C_SAT_POS : w_scaled[23:0];
  assign w_res     = r_sgn ? (24'd0 - w_res_mag) : w_res_mag;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_NORM;
      S_NORM:  w_state_next = S_SEED;
      S_SEED:  w_state_next = S_MUL_A;
      S_MUL_A: w_state_next = S_MUL_B;
      S_MUL_B: w_state_next = (r_it == IT_LAST) ? S_OUT : S_MUL_A;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sgn  <= 1'b0;
      r_mag  <= '0;
      r_lz   <= '0;
      r_d    <= '0;
      r_x    <= '0;
      r_t    <= '0;
      r_it   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_data <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sgn  <= i_data[23];
            r_mag  <= w_mag_in;
            r_busy <= 1'b1;
          end
        end
        S_NORM: begin
          r_lz <= w_lz;
          r_d  <= r_mag << w_lz;
        end
        S_SEED: begin
          r_x  <= C_SEED_OFS - w_prod[47:24];
          r_it <= '0;
        end
        S_MUL_A: r_t <= w_prod[47:24];
        S_MUL_B: begin
          // Only a zero operand can overflow here, and that result is saturated anyway.
          r_x <= w_prod[45:22];
          if (r_it != IT_LAST) r_it <= r_it + 2'd1;
        end
        S_OUT: begin
          r_data <= w_res;
          r_sat  <= w_res_sat;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_data = r_data;
  assign o_sat  = r_sat;

endmodule

// File: tb/tb_reciprocal_seq.sv
// Scoreboard bench for reciprocal_seq: ITERS=3 and ITERS=4 instances checked against an
// ideal round(2^24/x) model with a +/-2 LSB bound, saturation and fixed latency.
module tb_reciprocal_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start3, start4;
  logic [23:0] din3, din4;
  logic        busy3, done3, sat3;
  logic        busy4, done4, sat4;
  logic [23:0] dout3, dout4;

  always #5 clk = ~clk;

  reciprocal_seq #(.ITERS(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start3), .i_data(din3),
    .o_busy(busy3), .o_done(done3), .o_data(dout3), .o_sat(sat3)
  );

  reciprocal_seq #(.ITERS(4)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start4), .i_data(din4),
    .o_busy(busy4), .o_done(done4), .o_data(dout4), .o_sat(sat4)
  );

  typedef struct {
    logic [23:0] op;
    int          acc;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%06h want=%06h", name, got, want);
    end
  endtask

  // Reference: ideal reciprocal of the Q12.12 value, i.e. round(2^24 / |x|) with sign.
  task automatic check_op(input int which, input logic [23:0] op, input logic [23:0] got,
                          input logic got_sat, input int lat);
    longint sv, mag, ideal, want, gotv, diff;
    bit     neg, must_sat, may_sat;
    int     want_lat;
    want_lat = 2 * which + 3;
    sv  = longint'($signed(op));
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    if (mag == 0) begin
      ideal = 0; must_sat = 1'b1; may_sat = 1'b1;
    end else begin
      ideal    = ((longint'(1) << 25) / mag + 1) / 2;
      must_sat = (ideal > 64'sd8388609);
      may_sat  = (ideal >= 64'sd8388605);
    end
    $display("dut%0d op=%06h data=%06h sat=%0b lat=%0d ideal=%0d", which, op, got, got_sat, lat, ideal);

    n_checks++;
    if (lat != want_lat) begin
      n_errors++;
      $display("FAIL latency dut%0d op=%06h got=%0d want=%0d", which, op, lat, want_lat);
    end

    n_checks++;
    if ((must_sat && !got_sat) || (!may_sat && got_sat)) begin
      n_errors++;
      $display("FAIL sat dut%0d op=%06h got=%0b want=%0b", which, op, got_sat, must_sat);
    end

    n_checks++;
    gotv = longint'($signed(got));
    if (got_sat) begin
      want = neg ? -64'sd8388607 : 64'sd8388607;
      if (gotv != want) begin
        n_errors++;
        $display("FAIL sat_value dut%0d op=%06h got=%0d want=%0d", which, op, gotv, want);
      end
    end else begin
      want = neg ? -ideal : ideal;
      diff = gotv - want;
      if (diff > 2 || diff < -2) begin
        n_errors++;
        $display("FAIL value dut%0d op=%06h got=%0d want=%0d+/-2", which, op, gotv, want);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_done dut3 got=%06h want=no_done", dout3);
      end else begin
        e = q3.pop_front();
        check_op(3, e.op, dout3, sat3, cyc - e.acc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_done dut4 got=%06h want=no_done", dout4);
      end else begin
        e = q4.pop_front();
        check_op(4, e.op, dout4, sat4, cyc - e.acc);
      end
    end
  end

  task automatic issue(input int which, input logic [23:0] op);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (((which == 3) ? busy3 : busy4) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout dut%0d busy=1 want busy=0", which);
      return;
    end
    if (which == 3) begin start3 = 1'b1; din3 = op; end
    else            begin start4 = 1'b1; din4 = op; end
    @(posedge clk);
    #1;
    e.op  = op;
    e.acc = cyc;
    if (which == 3) begin q3.push_back(e); start3 = 1'b0; end
    else            begin q4.push_back(e); start4 = 1'b0; end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q3.size() != 0 || q4.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout pending=%0d want=0", q3.size() + q4.size());
    end
    @(negedge clk);
  endtask

  function automatic logic [23:0] rand_op();
    logic [23:0] m;
    m = 24'($urandom()) >> $urandom_range(0, 22);
    if (m == 24'd0) m = 24'd1;
    if ($urandom_range(0, 1) == 1) m = 24'd0 - m;
    return m;
  endfunction

  logic [23:0] directed [9] = '{24'h001000, 24'h002000, 24'hFFC000, 24'h000800, 24'h000000,
                                24'h000001, 24'hFFFFFF, 24'h7FF000, 24'h800000};

  initial begin
    rst_n = 1'b0; start3 = 1'b0; start4 = 1'b0; din3 = '0; din4 = '0;
    #12;
    check_eq("reset_busy3", 24'(busy3), 24'd0);
    check_eq("reset_done3", 24'(done3), 24'd0);
    check_eq("reset_data3", dout3, 24'd0);
    check_eq("reset_sat3",  24'(sat3),  24'd0);
    check_eq("reset_busy4", 24'(busy4), 24'd0);
    check_eq("reset_data4", dout4, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) issue(3, directed[i]);
    issue(4, 24'h001000);
    issue(4, 24'h800000);
    wait_drain();

    // Back-to-back: each issue lands in the previous op's done cycle.
    for (int i = 0; i < 4; i++) issue(3, rand_op());
    wait_drain();

    // Start pulses while busy must be ignored.
    issue(3, 24'h00C000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start3 = 1'b1;
      din3   = rand_op();
    end
    @(negedge clk);
    start3 = 1'b0;
    wait_drain();

    // Reset during the first MUL_B of an operation.
    issue(3, 24'h003000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy3", 24'(busy3), 24'd0);
    check_eq("abort_done3", 24'(done3), 24'd0);
    check_eq("abort_data3", dout3, 24'd0);
    check_eq("abort_sat3",  24'(sat3),  24'd0);
    q3.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(3, 24'h004000);
    wait_drain();

    fork
      begin
        for (int i = 0; i < 3000; i++) issue(3, rand_op());
      end
      begin
        for (int i = 0; i < 3000; i++) issue(4, rand_op());
      end
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t want=finish_earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
